// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the memory line responder: interface widths, default
// latency, FSM state encoding and the latency-jitter LFSR step.
// MEM_JITTER_EN widens the latency counter to hold LATENCY-1 plus up to 7 extra cycles.
package mem_line_responder_pkg;

  localparam int MEM_ADDR_W  = 28;
  localparam int MEM_DATA_W  = 128;
  localparam int MEM_IDX_W   = 8;
  localparam int MEM_LATENCY = 4;

`ifdef MEM_JITTER_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/mem_line_responder_lfsr.sv
// mem_lat_lfsr: extra-latency source for the memory line responder.
// Only compiled when MEM_JITTER_EN is defined; advances once per accepted request
// and exposes its low three bits as the extra latency for that request.
`ifdef MEM_JITTER_EN
module mem_lat_lfsr
  import mem_line_responder_pkg::*;
(
  input  logic       clk,
  input  logic       proc_reset_n,
  input  logic       step,
  output logic [2:0] rnd
);

  logic [7:0] lfsr_q;

  // Seeded at reset, stepped on each accept.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign rnd = lfsr_q[2:0];

endmodule
`endif

// File: rtl/mem_line_responder.sv
// mem_line_responder: memory-side responder for the 128-bit line interface.
// Accepts a held read or write, waits a programmable latency, then pulses
// mem_ready for one cycle. Requests are served from an internal line array
// indexed by the low IDX_W address bits (upper bits alias).
// Build macro MEM_JITTER_EN adds 0..7 cycles of LFSR-driven extra latency.
// Reset asserts asynchronously; its release is expected to be synchronous to clk.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; a request seen on the edge is accepted
// WAIT  | counting down the captured latency; request inputs are ignored
// RESP  | mem_ready high for this cycle; a captured write commits at its end
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int IDX_W   = MEM_IDX_W,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int DEPTH = 1 << IDX_W;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_load;
  logic              wr_q, wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              unused_addr_bits;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign accept           = (state_q == ST_IDLE) && (mem_read || mem_write);
  assign unused_addr_bits = ^mem_addr[ADDR_W-1:IDX_W];

`ifdef MEM_JITTER_EN
  logic [2:0] rnd;

  mem_lat_lfsr u_lat_lfsr (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .step         (accept),
    .rnd          (rnd)
  );

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(rnd);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  // Capture is final at accept: write wins over read when both are high.
  assign wr_d    = accept ? mem_write : wr_q;
  assign idx_d   = accept ? mem_addr[IDX_W-1:0] : idx_q;
  assign wdata_d = accept ? mem_wdata : wdata_q;

  // State and latency counter register.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: RESP is entered on the edge where the counter would reach zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = cnt_load;
          state_d = (cnt_load == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: ready and read data are loaded on the edge into RESP so both are registered.
  always_comb begin
    ready_d = (state_d == ST_RESP);
    rdata_d = rdata_q;
    if ((state_d == ST_RESP) && !wr_d) begin
      rdata_d = mem_q[idx_d];
    end
    busy = (state_q == ST_WAIT) || (state_q == ST_RESP);
  end

  // Captured request fields and registered outputs.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  // Line array write: commits at the end of RESP; an aborted transaction never reaches RESP.
  always_ff @(posedge clk) begin
    if ((state_q == ST_RESP) && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed cases plus randomized traffic checked
// against a line-array model and the nominal request-to-ready latency.
module tb_mem_line_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         proc_reset_n = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [27:0]  mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] model_mem [256];
  logic [127:0] last_rd;
  logic [15:0]  lat_seen = '0;

  mem_line_responder dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one request at the current negedge (cycle t) and follow it to completion.
  // keep=1 leaves the request asserted into the IDLE cycle after RESP; the caller
  // must then issue the next request immediately.
  task automatic run_txn(input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [127:0] wdata, input bit keep);
    int         lat;
    bit         seen;
    logic       busy_early;
    logic [7:0] idx;
    mem_read   = rd;
    mem_write  = wr;
    mem_addr   = addr;
    mem_wdata  = wdata;
    idx        = addr[7:0];
    lat        = 0;
    seen       = 1'b0;
    busy_early = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) busy_early = busy;
      if (mem_ready) seen = 1'b1;
    end
`ifdef MEM_JITTER_EN
    chk("lat_range", 128'(seen && lat >= LAT && lat <= LAT + 7), 128'd1);
    if (seen && lat < 16) lat_seen[lat] = 1'b1;
`else
    chk("latency", 128'(lat), 128'(LAT));
`endif
    if (LAT > 1) chk("busy_wait", 128'(busy_early), 128'd1);
    if (!keep) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    if (wr) begin
      chk("rdata_hold", mem_rdata, last_rd);
      model_mem[idx] = wdata;
    end else begin
      chk("rdata", mem_rdata, model_mem[idx]);
      last_rd = model_mem[idx];
    end
    @(negedge clk);
    chk("ready_single", 128'(mem_ready), 128'd0);
    chk("busy_idle", 128'(busy), 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    bit          keep;
    int          op;

    repeat (3) @(negedge clk);
    proc_reset_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 128'(mem_ready), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_rdata", mem_rdata, 128'd0);
    last_rd = '0;

    // Fill every line so each later read has a known expectation; upper address bits random.
    for (int i = 0; i < 256; i++) begin
      r = $urandom();
      run_txn(1'b0, 1'b1, {r[19:0], 8'(i)}, rand_line(), 1'b0);
    end

    // Write then read a fixed line.
    run_txn(1'b0, 1'b1, 28'h0000012, 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF, 1'b0);
    run_txn(1'b1, 1'b0, 28'h0000012, '0, 1'b0);
    chk("dir_rd_12", mem_rdata, 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF);

    // Read and write both high: treated as a write.
    run_txn(1'b1, 1'b1, 28'h0000005, {128{1'b1}}, 1'b0);
    run_txn(1'b1, 1'b0, 28'h0000005, '0, 1'b0);
    chk("dir_both_wr", mem_rdata, {128{1'b1}});

    // Index aliasing through the upper address bits.
    run_txn(1'b0, 1'b1, 28'h0000105, 128'h1, 1'b0);
    run_txn(1'b1, 1'b0, 28'h0000005, '0, 1'b0);
    chk("dir_alias", mem_rdata, 128'h1);

    // Back-to-back: request held into the IDLE cycle after RESP is a new transaction.
    run_txn(1'b0, 1'b1, 28'h0000033, rand_line(), 1'b1);
    run_txn(1'b1, 1'b0, 28'h0000033, '0, 1'b1);
    run_txn(1'b1, 1'b0, 28'h0000077, '0, 1'b0);

    // Reset in the middle of a write's wait: outputs clear at once, write is dropped.
    run_txn(1'b1, 1'b0, 28'h00000AB, '0, 1'b0);
    mem_write = 1'b1;
    mem_addr  = 28'h00000AB;
    mem_wdata = ~model_mem[8'hAB];
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b0;
    #1;
    chk("rst_async_ready", 128'(mem_ready), 128'd0);
    chk("rst_async_busy", 128'(busy), 128'd0);
    chk("rst_async_rdata", mem_rdata, 128'd0);
    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b1;
    @(negedge clk);
    last_rd = '0;
    run_txn(1'b1, 1'b0, 28'h00000AB, '0, 1'b0);

    // 64 reads at random addresses; latency checked on each.
    lat_seen = '0;
    for (int i = 0; i < 64; i++) begin
      r = $urandom();
      run_txn(1'b1, 1'b0, r[27:0], '0, 1'b0);
    end
`ifdef MEM_JITTER_EN
    chk("lat_distinct", 128'($countones(lat_seen) >= 4), 128'd1);
`endif

    // Random mix of reads, writes and both-high, with gaps and back-to-back holds.
    for (int k = 0; k < 150; k++) begin
      r    = $urandom();
      op   = $urandom_range(0, 2);
      keep = (k < 149) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn((op != 1), (op != 0), r[27:0], rand_line(), keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
